// File: rtl/ps2_bus_monitor_if.sv
// PS/2 line taps and entry-FIFO read port of ps2_bus_monitor.
// master drives the lines and read controls; slave is the monitor.
interface ps2_bus_monitor_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

    logic              ps2c;
    logic              ps2d;
    logic              rd_en;
    logic              clr_overflow;
    logic [11:0]       rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              frame_tick;

    modport master (
        output ps2c, ps2d, rd_en, clr_overflow,
        input  rd_data, empty, full, count, overflow, frame_tick
    );

    modport slave (
        input  ps2c, ps2d, rd_en, clr_overflow,
        output rd_data, empty, full, count, overflow, frame_tick
    );
endinterface

// File: rtl/ps2_bus_monitor.sv
// Passive PS/2 snooper: decodes D2H and H2D frames, flags parity/frame/timeout
// errors and queues one 12-bit entry per frame in a first-word fall-through FIFO.
module ps2_bus_monitor #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    ps2_bus_monitor_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned LOW_W  = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BIT_W  = 4;

    typedef struct packed {
        logic       dir;
        logic       err_parity;
        logic       err_frame;
        logic       err_timeout;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_D2H,
        S_INHIBIT,
        S_H2D,
        S_ACK
    } state_t;

    // index 0 = clock line, index 1 = data line
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [FCNT_W-1:0] fcnt [2];
    logic              filt_c_q;
    logic              c_fall;
    logic              c_rise;

    logic [LOW_W-1:0]  low_cnt;
    logic              low_long;
    logic [TO_W-1:0]   to_cnt;
    logic              in_frame;
    logic              timeout_hit;

    state_t            state, state_n;
    logic [7:0]        data_q, data_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic              par_q, par_n;
    logic              stop_q, stop_n;
    logic              push_c;
    entry_t            entry_c;
    logic              frame_tick_q;
    entry_t            entry_q;

    entry_t            mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              empty_q;
    logic              full_q;
    logic              overflow_q;
    entry_t            rd_data_q;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic              head_load;
    entry_t            head_n;

    // Synchronizer and glitch filter; a line only moves after FILTER_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= '1;
            sync2    <= '1;
            filt     <= '1;
            filt_c_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1    <= {bus.ps2d, bus.ps2c};
            sync2    <= sync1;
            filt_c_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    assign c_fall = filt_c_q & ~filt[0];
    assign c_rise = ~filt_c_q & filt[0];

    // Clock-low duration (inhibit detection) and inter-edge timeout counters
    always_ff @(posedge clk) begin
        if (!reset || filt[0]) begin
            low_cnt <= '0;
        end else if (low_cnt != LOW_W'(INHIBIT_CYC)) begin
            low_cnt <= low_cnt + LOW_W'(1);
        end
    end

    assign low_long = ~filt[0] && (low_cnt >= LOW_W'(INHIBIT_CYC - 1));
    assign in_frame = (state == S_D2H) || (state == S_H2D) || (state == S_ACK);

    always_ff @(posedge clk) begin
        if (!reset || !in_frame || c_fall || c_rise) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = in_frame && (to_cnt == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_RESYNC;
            data_q       <= '0;
            bit_q        <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            entry_q      <= '0;
        end else begin
            state        <= state_n;
            data_q       <= data_n;
            bit_q        <= bit_n;
            par_q        <= par_n;
            stop_q       <= stop_n;
            frame_tick_q <= push_c;
            entry_q      <= entry_c;
        end
    end

    // Frame decoder: bit index 0..7 data, 8 parity, 9 stop
    always_comb begin
        state_n = state;
        data_n  = data_q;
        bit_n   = bit_q;
        par_n   = par_q;
        stop_n  = stop_q;
        push_c  = 1'b0;
        entry_c = '0;
        unique case (state)
            S_RESYNC: begin
                if (filt[0] && filt[1]) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (c_fall && !filt[1]) begin
                    state_n = S_D2H;
                    data_n  = '0;
                    bit_n   = '0;
                end else if (low_long) begin
                    state_n = S_INHIBIT;
                end
            end
            S_D2H: begin
                if (low_long || timeout_hit) begin
                    push_c              = 1'b1;
                    entry_c.err_timeout = 1'b1;
                    entry_c.data        = data_q;
                    state_n             = low_long ? S_INHIBIT : S_RESYNC;
                end else if (c_fall) begin
                    bit_n = bit_q + BIT_W'(1);
                    if (bit_q < BIT_W'(8)) begin
                        data_n[bit_q[2:0]] = filt[1];
                    end else if (bit_q == BIT_W'(8)) begin
                        par_n = filt[1];
                    end else begin
                        push_c             = 1'b1;
                        entry_c.err_parity = ~^{par_q, data_q};
                        entry_c.err_frame  = ~filt[1];
                        entry_c.data       = data_q;
                        state_n            = S_IDLE;
                    end
                end
            end
            S_INHIBIT: begin
                if (c_rise) begin
                    state_n = filt[1] ? S_IDLE : S_H2D;
                    data_n  = '0;
                    bit_n   = '0;
                end
            end
            S_H2D: begin
                if (timeout_hit) begin
                    push_c              = 1'b1;
                    entry_c.dir         = 1'b1;
                    entry_c.err_timeout = 1'b1;
                    entry_c.data        = data_q;
                    state_n             = S_RESYNC;
                end else if (c_rise) begin
                    bit_n = bit_q + BIT_W'(1);
                    if (bit_q < BIT_W'(8)) begin
                        data_n[bit_q[2:0]] = filt[1];
                    end else if (bit_q == BIT_W'(8)) begin
                        par_n = filt[1];
                    end else begin
                        stop_n  = filt[1];
                        state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (timeout_hit) begin
                    push_c              = 1'b1;
                    entry_c.dir         = 1'b1;
                    entry_c.err_timeout = 1'b1;
                    entry_c.data        = data_q;
                    state_n             = S_RESYNC;
                end else if (c_fall) begin
                    push_c             = 1'b1;
                    entry_c.dir        = 1'b1;
                    entry_c.err_parity = ~^{par_q, data_q};
                    entry_c.err_frame  = ~stop_q | filt[1];
                    entry_c.data       = data_q;
                    state_n            = S_IDLE;
                end
            end
            default: state_n = S_RESYNC;
        endcase
    end

    // FIFO control; a push while full is only accepted alongside a pop
    always_comb begin
        do_pop    = bus.rd_en && !empty_q;
        do_push   = frame_tick_q && (!full_q || do_pop);
        drop      = frame_tick_q && full_q && !do_pop;
        cnt_n     = cnt_q;
        if (do_push && !do_pop) cnt_n = cnt_q + CNT_W'(1);
        if (!do_push && do_pop) cnt_n = cnt_q - CNT_W'(1);
        head_load = 1'b0;
        head_n    = rd_data_q;
        if (do_pop && (cnt_q > CNT_W'(1))) begin
            head_load = 1'b1;
            head_n    = mem[rd_ptr + ADDR_W'(1)];
        end else if (do_push && (empty_q || do_pop)) begin
            head_load = 1'b1;
            head_n    = entry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt_q   <= cnt_n;
            empty_q <= (cnt_n == '0);
            full_q  <= (cnt_n == CNT_W'(FIFO_DEPTH));
            if (head_load) rd_data_q <= head_n;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.count      = cnt_q;
    assign bus.overflow   = overflow_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_ps2_bus_monitor.sv
// Scoreboard bench for ps2_bus_monitor: directed frames plus randomized traffic,
// expected entries derived from the PS/2 frame rules and popped by a read monitor.
module tb_ps2_bus_monitor;
    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned INHIBIT_CYC = 200;
    localparam int unsigned TIMEOUT_CYC = 1000;
    localparam int unsigned DEPTH       = 16;
    localparam int          HP          = 20;
    localparam int          INH_HOLD    = 300;

    logic clk;
    logic reset;

    ps2_bus_monitor_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_bus_monitor #(
        .FILTER_LEN (FILTER_LEN),
        .INHIBIT_CYC(INHIBIT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] exp_q [$];
    int          errors;
    int          checks;
    int          tick_cnt;
    int          exp_ticks;
    int          rd_req;
    int          rd_done;
    bit          reader_on;
    bit          ov_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Queue the expected entry ahead of the frame; a full FIFO with no reader drops it
    task automatic expect_entry(input logic [11:0] e);
        exp_ticks++;
        if (!reader_on && exp_q.size() >= DEPTH) ov_model = 1'b1;
        else exp_q.push_back(e);
    endtask

    // Device-to-host: data changes while clock is high, sampled on falling edge
    task automatic d2h_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2d = f[i];
            wait_cyc(HP / 2);
            bus.ps2c = 1'b0;
            wait_cyc(HP);
            bus.ps2c = 1'b1;
            wait_cyc(HP / 2);
        end
        bus.ps2d = 1'b1;
    endtask

    task automatic d2h_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        expect_entry({1'b0, par_bad, ~stop, 1'b0, b});
        d2h_bits({stop, odd_par(b) ^ par_bad, b, 1'b0}, 11);
        wait_cyc(10);
    endtask

    // Host-to-device: inhibit, start, 10 bits sampled on rising edges, ack on falling edge
    task automatic h2d_frame(input logic [7:0] b, input logic par_bad, input logic stop, input logic ack);
        logic [9:0] bits;
        bits = {stop, odd_par(b) ^ par_bad, b};
        expect_entry({1'b1, par_bad, ~stop | ack, 1'b0, b});
        bus.ps2c = 1'b0;
        wait_cyc(INH_HOLD);
        bus.ps2d = 1'b0;
        wait_cyc(HP / 2);
        bus.ps2c = 1'b1;
        wait_cyc(HP);
        for (int i = 0; i < 10; i++) begin
            bus.ps2c = 1'b0;
            wait_cyc(HP / 2);
            bus.ps2d = bits[i];
            wait_cyc(HP / 2);
            bus.ps2c = 1'b1;
            wait_cyc(HP);
        end
        bus.ps2d = ack;
        wait_cyc(HP / 2);
        bus.ps2c = 1'b0;
        wait_cyc(HP);
        bus.ps2c = 1'b1;
        wait_cyc(HP / 2);
        bus.ps2d = 1'b1;
        wait_cyc(HP);
    endtask

    task automatic read_n(input int n);
        int budget;
        rd_req += n;
        budget = 0;
        while (rd_done < rd_req && budget < 200) begin
            wait_cyc(1);
            budget++;
        end
        if (rd_done < rd_req) begin
            errors++;
            checks++;
            $display("FAIL read_wait: done %0d, requested %0d", rd_done, rd_req);
            rd_done = rd_req;
        end
        wait_cyc(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors    = 0;
        checks    = 0;
        tick_cnt  = 0;
        exp_ticks = 0;
        rd_req    = 0;
        rd_done   = 0;
        reader_on = 1'b0;
        ov_model  = 1'b0;
        reset     = 1'b0;
        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rd_en = 1'b0;
        bus.clr_overflow = 1'b0;

        // Read monitor: pops the head whenever a read is issued and compares it
        fork
            forever begin
                logic       rd_next;
                logic [11:0] e;
                @(negedge clk);
                if (bus.frame_tick === 1'b1) tick_cnt++;
                rd_next = reset && !bus.empty &&
                          ((reader_on && $urandom_range(0, 3) != 0) || (rd_done < rd_req));
                if (rd_next) begin
                    if (rd_done < rd_req) rd_done++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop: unexpected entry %03h", bus.rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.rd_data !== e) begin
                            errors++;
                            $display("FAIL pop: got %03h, expected %03h", bus.rd_data, e);
                        end
                    end
                end
                bus.rd_en = rd_next;
            end
        join_none

        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(3);
        chk("reset_empty", 32'(bus.empty), 1);
        chk("reset_full", 32'(bus.full), 0);
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_rd_data", 32'(bus.rd_data), 0);
        chk("reset_overflow", 32'(bus.overflow), 0);
        chk("reset_tick", 32'(bus.frame_tick), 0);

        // D2H 0x1C with latency check: tick, then entry visible one cycle later
        begin
            int n;
            logic [10:0] f;
            f = {1'b1, odd_par(8'h1C), 8'h1C, 1'b0};
            expect_entry(12'h01C);
            d2h_bits(f, 10);
            bus.ps2d = f[10];
            wait_cyc(HP / 2);
            bus.ps2c = 1'b0;
            n = 0;
            while (bus.frame_tick !== 1'b1 && n < 50) begin
                wait_cyc(1);
                n++;
            end
            chk("tick_seen", 32'(bus.frame_tick), 1);
            chk("tick_cycle_empty", 32'(bus.empty), 1);
            wait_cyc(1);
            chk("lat_tick_low", 32'(bus.frame_tick), 0);
            chk("lat_empty", 32'(bus.empty), 0);
            chk("lat_count", 32'(bus.count), 1);
            chk("lat_rd_data", 32'(bus.rd_data), 32'h01C);
            wait_cyc(HP);
            bus.ps2c = 1'b1;
            wait_cyc(HP);
            bus.ps2d = 1'b1;
        end
        read_n(1);
        chk("after_read_empty", 32'(bus.empty), 1);

        h2d_frame(8'hED, 1'b0, 1'b1, 1'b0);
        chk("h2d_count", 32'(bus.count), 1);
        read_n(1);
        d2h_frame(8'h1C, 1'b1, 1'b0);
        h2d_frame(8'hED, 1'b0, 1'b1, 1'b1);
        chk("err_count", 32'(bus.count), 2);
        read_n(2);

        // Stall after start + 4 data bits, clock left high
        expect_entry(12'h10C);
        d2h_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 5);
        wait_cyc(TIMEOUT_CYC + 100);
        chk("stall_count", 32'(bus.count), 1);
        chk("stall_rd_data", 32'(bus.rd_data), 32'h10C);
        read_n(1);
        d2h_frame(8'h1C, 1'b0, 1'b1);
        read_n(1);
        chk("ticks_directed", 32'(tick_cnt), 32'(exp_ticks));

        // 17 frames with no reads: last one dropped
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("pre_drop_overflow", 32'(bus.overflow), 0);
            d2h_frame(8'(i), 1'b0, 1'b1);
        end
        chk("ovf_full", 32'(bus.full), 1);
        chk("ovf_count", 32'(bus.count), DEPTH);
        chk("ovf_flag", 32'(bus.overflow), 32'(ov_model));
        chk("ovf_ticks", 32'(tick_cnt), 32'(exp_ticks));
        @(negedge clk) bus.clr_overflow = 1'b1;
        @(negedge clk) bus.clr_overflow = 1'b0;
        ov_model = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 0);
        read_n(DEPTH);
        chk("ovf_drained", 32'(bus.empty), 1);

        // Reset mid-frame discards both the held entry and the partial frame
        d2h_frame(8'h55, 1'b0, 1'b1);
        chk("pre_reset_count", 32'(bus.count), 1);
        d2h_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 5);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        exp_q.delete();
        wait_cyc(TIMEOUT_CYC + 100);
        chk("mid_reset_empty", 32'(bus.empty), 1);
        chk("mid_reset_count", 32'(bus.count), 0);
        chk("mid_reset_rd_data", 32'(bus.rd_data), 0);
        chk("mid_reset_ticks", 32'(tick_cnt), 32'(exp_ticks));
        d2h_frame(8'h1C, 1'b0, 1'b1);
        read_n(1);

        // Randomized traffic with a random-rate reader
        reader_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic pb, st, ak;
            b  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) != 0);
            ak = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) h2d_frame(b, pb, st, ak);
            else d2h_frame(b, pb, st);
        end
        begin
            int n;
            n = 0;
            while ((exp_q.size() != 0 || bus.empty !== 1'b1) && n < 500) begin
                wait_cyc(1);
                n++;
            end
        end
        reader_on = 1'b0;
        wait_cyc(4);
        chk("rand_exp_left", 32'(exp_q.size()), 0);
        chk("rand_empty", 32'(bus.empty), 1);
        chk("rand_ticks", 32'(tick_cnt), 32'(exp_ticks));
        chk("rand_overflow", 32'(bus.overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_bus_monitor.md
Name: ps2_bus_monitor

Overview:
Synthesizable, passive PS/2 line snooper. Decodes both device-to-host (D2H) and host-to-device (H2D) frames on ps2c/ps2d and checks parity, stop and ack. Detects stalled or aborted frames and queues one 12-bit status/data entry per frame in an internal FWFT FIFO. Used as a bus-level checker on hardware and as a self-checking monitor in the keyboard-interface bench; it never drives the bus.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before a filtered line changes
INHIBIT_CYC, 5000, cycles of filtered clock low that count as host inhibit / request-to-send (100 us at 50 MHz)
TIMEOUT_CYC, 100000, maximum cycles between filtered clock edges inside a frame (2 ms at 50 MHz); must exceed INHIBIT_CYC
FIFO_DEPTH, 16, entry FIFO depth; power of two, at least 2
ADDR_W, $clog2(FIFO_DEPTH), derived

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
ps2c  in  1  PS/2 clock line, asynchronous, observe only
ps2d  in  1  PS/2 data line, asynchronous, observe only
rd_en  in  1  pop head entry; ignored when empty
rd_data  out  12  head entry {dir, err_parity, err_frame, err_timeout, data[7:0]}; dir 1 = H2D
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  ADDR_W+1  entries held
overflow  out  1  sticky; set when a completed frame is dropped because the FIFO is full
clr_overflow  in  1  clears overflow; set wins if it coincides with a drop
frame_tick  out  1  one-cycle pulse per completed or aborted frame, including dropped ones

Behaviour:
- Reset is synchronous and active-low. It clears the FIFO and clears overflow and frame_tick. Outputs during and after reset: empty=1, full=0, count=0, rd_data=0. Filtered lines reset to 1. The FSM goes to RESYNC and any partial frame is discarded.
- Input path: 2-FF synchronizer, then a glitch filter with a FILTER_LEN counter. Falling and rising edges of the filtered clock are single-cycle strobes.
- FSM states: RESYNC, IDLE, D2H, INHIBIT, H2D, ACK.
- RESYNC -> IDLE when filtered clock and filtered data are both 1 in the same cycle.
- IDLE -> D2H on a clock falling edge with data=0 (start bit). Shift register and bit counter are cleared.
- IDLE -> INHIBIT when the clock has been low for INHIBIT_CYC cycles.
- D2H: data is sampled on each clock falling edge: 8 data bits LSB first, then parity, then stop. At the stop edge the entry is pushed with dir=0, then the FSM goes to IDLE.
- INHIBIT -> H2D on a clock rising edge while data=0 (host start). INHIBIT -> IDLE on a clock rising edge while data=1.
- H2D: data is sampled on clock rising edges: 8 data bits LSB first, parity, stop. The FSM then moves to ACK.
- ACK: data is sampled on the next clock falling edge; 0 is a valid ack. The entry is pushed with dir=1 and the FSM goes to IDLE.
- err_parity = ~^{parity, data} (odd parity required).
- err_frame: set when the stop sample is 0 (both directions) or the ack sample is 1.
- Timeout: in D2H, H2D or ACK, a counter is cleared on every filtered clock edge. Abort when either occurs:
  - the counter reaches TIMEOUT_CYC, or
  - in D2H only, the clock is held low for INHIBIT_CYC.
- On abort, an entry is pushed with err_timeout=1 and err_parity=err_frame=0. data holds the bits received so far in the LSBs, with the rest 0. The next state is INHIBIT for the D2H inhibit case and RESYNC otherwise.
- Latency:
  - frame_tick is high the cycle after the final sampling strobe (or the abort condition).
  - The entry is visible on rd_data, with empty/count updated, one cycle after frame_tick.
- FIFO: first-word fall-through; rd_data shows the head whenever empty=0 and holds its last value when empty.
  - Push and pop in the same cycle are both performed and count is unchanged. This includes the full case, where nothing is dropped.
  - Push when full without a pop drops the entry and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- D2H frame 0x1C, parity 0, stop 1 -> frame_tick pulse; rd_data=12'h01C; count=1; after rd_en, empty=1.
- H2D: clock low 6000 cycles, data low, clock released, device clocks 0xED with parity 1, stop 1, ack 0 -> rd_data=12'h8ED.
- D2H 0x1C with parity 1 and stop 0 -> rd_data=12'h61C. H2D 0xED with ack left high -> rd_data=12'hAED.
- D2H stalls after start + 4 data bits of 0x1C, clock held high -> after TIMEOUT_CYC, entry 12'h10C. Next good frame decodes correctly after RESYNC.
- 17 back-to-back good D2H frames 0x00..0x10, no reads -> full=1, count=16, overflow=1. Reads return 0x00..0x0F in order. clr_overflow clears overflow.
- reset=0 for one cycle mid D2H frame -> FIFO empty, no entry from the partial frame; the following frame 0x1C gives 12'h01C.
